// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the instruction loader state encoding.
package cpu_pkg;
  localparam int INST_W        = 10;
  localparam int HALF_W        = 5;
  localparam int PC_W          = 16;
  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX_HI = 2'd1,
    RX_LO = 2'd2,
    DONE  = 2'd3
  } loader_state_t;
endpackage

// File: rtl/inst_bank_ram.sv
// One program bank: single synchronous write port, asynchronous read port.
module inst_bank_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-during-write returns the pre-edge contents.
  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_loader.sv
// Writable two-bank instruction store fed by a half-word valid/ready stream; holds the CPU while loading.
// Optional LOADER_CHECKSUM_EN: final word is an XOR checksum of the written words instead of data.
module inst_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 8
) (
  input  logic              CLK,
  input  logic              Init,
  input  logic              LoadStart,
  input  logic              LoadBank,
  input  logic              LoadValid,
  input  logic [HALF_W-1:0] LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  input  logic [PC_W-1:0]   InstAddress,
  input  logic              Program,
  output logic [INST_W-1:0] InstOut,
  output logic              CpuInit,
  output logic              LoadDone,
  output logic              LoadError,
  output logic [AW:0]       WordCount
);
  loader_state_t     state, state_nxt;
  logic              bank;
  logic [HALF_W-1:0] hi;
  logic              first_done;
  logic              xfer, start, full, lo_xfer, csum_word, we;
  logic [INST_W-1:0] word, rd0, rd1;

  assign LoadReady = Init && ((state == RX_HI) || (state == RX_LO));
  assign xfer      = LoadValid && LoadReady;
  assign lo_xfer   = xfer && (state == RX_LO);
  assign start     = LoadStart && ((state == IDLE) || (state == DONE));
  assign full      = (WordCount == (AW+1)'(DEPTH));
  assign word      = {hi, LoadData};

`ifdef LOADER_CHECKSUM_EN
  logic [INST_W-1:0] csum;
  assign csum_word = LoadLast;
`else
  assign csum_word = 1'b0;
`endif

  assign we = lo_xfer && !csum_word && !full;

  // CPU is held during reset, while receiving, and on the first DONE cycle.
  assign CpuInit = !Init || (state == RX_HI) || (state == RX_LO) ||
                   ((state == DONE) && first_done);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (LoadStart) state_nxt = RX_HI;
      RX_HI:      if (xfer) state_nxt = RX_LO;
      RX_LO:      if (xfer) state_nxt = LoadLast ? DONE : RX_HI;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Init) begin
      state      <= IDLE;
      WordCount  <= '0;
      LoadDone   <= 1'b0;
      LoadError  <= 1'b0;
      first_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      first_done <= lo_xfer && LoadLast;
      if (start) begin
        bank      <= LoadBank;
        WordCount <= '0;
        LoadDone  <= 1'b0;
        LoadError <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum      <= '0;
`endif
      end
      if (xfer && (state == RX_HI)) hi <= LoadData;
      if (lo_xfer) begin
        if (LoadLast) LoadDone <= 1'b1;
        if (!csum_word) begin
          if (full) LoadError <= 1'b1;
          else      WordCount <= WordCount + 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        if (we) csum <= csum ^ word;
        if (csum_word && (csum != word)) LoadError <= 1'b1;
`endif
      end
    end
  end

  inst_bank_ram #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk(CLK), .we(we && !bank), .waddr(WordCount[AW-1:0]), .wdata(word),
    .raddr(InstAddress[AW-1:0]), .rdata(rd0)
  );

  inst_bank_ram #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk(CLK), .we(we && bank), .waddr(WordCount[AW-1:0]), .wdata(word),
    .raddr(InstAddress[AW-1:0]), .rdata(rd1)
  );

  assign InstOut = ({1'b0, InstAddress} < (PC_W+1)'(DEPTH)) ? (Program ? rd1 : rd0)
                                                          : '0;
endmodule

// File: tb/tb_inst_loader.sv
// Directed + randomized bench for inst_loader with a small-DEPTH instance and a word-level reference model.
module tb_inst_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          Init, LoadStart, LoadBank, LoadValid, LoadLast, Program;
  logic [4:0]    LoadData;
  logic [15:0]   InstAddress;
  logic          LoadReady, CpuInit, LoadDone, LoadError;
  logic [9:0]    InstOut;
  logic [AW:0]   WordCount;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [9:0]    mdl    [2][DEPTH];
  bit            mknown [2][DEPTH];
  int            exp_cnt;
  bit            exp_err;
  logic [9:0]    words [$];

  always #5 CLK = ~CLK;

  inst_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .Init(Init), .LoadStart(LoadStart), .LoadBank(LoadBank),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast),
    .LoadReady(LoadReady), .InstAddress(InstAddress), .Program(Program),
    .InstOut(InstOut), .CpuInit(CpuInit), .LoadDone(LoadDone),
    .LoadError(LoadError), .WordCount(WordCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Word-level expectation: data words fill addresses 0.. until DEPTH; checksum word (if enabled) is compared.
  task automatic model_load(input bit b);
    logic [9:0] x;
    bit         is_csum;
    x = '0; exp_cnt = 0; exp_err = 0;
    for (int i = 0; i < words.size(); i++) begin
`ifdef LOADER_CHECKSUM_EN
      is_csum = (i == words.size() - 1);
`else
      is_csum = 0;
`endif
      if (is_csum) begin
        if (x != words[i]) exp_err = 1;
      end else if (exp_cnt == DEPTH) begin
        exp_err = 1;
      end else begin
        mdl[b][exp_cnt] = words[i];
        mknown[b][exp_cnt] = 1;
        x ^= words[i];
        exp_cnt++;
      end
    end
  endtask

  task automatic send_half(input logic [4:0] d, input bit last, input bit gap,
                           input bit stray, input bit b);
    int waited;
    if (gap) begin
      LoadValid = 0;
      tick();
    end
    LoadData = d; LoadLast = last; LoadValid = 1;
    if (stray) begin
      LoadStart = 1; LoadBank = ~b;
    end
    waited = 0;
    while (!LoadReady && waited < 10) begin
      tick();
      waited++;
    end
    if (!LoadReady) chk("ready_timeout", LoadReady, 1);
    tick();
    LoadValid = 0; LoadLast = 0; LoadStart = 0;
  endtask

  task automatic do_load(input bit b, input bit gap, input bit stray);
    logic [9:0] w;
    LoadStart = 1; LoadBank = b;
    tick();
    LoadStart = 0;
    chk("ready_in_rx", LoadReady, 1);
    chk("cpuinit_in_rx", CpuInit, 1);
    chk("done_cleared", LoadDone, 0);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      send_half(w[9:5], 0, gap, 0, b);
      send_half(w[4:0], (i == words.size() - 1), gap, stray && (i == 0), b);
    end
    model_load(b);
    chk("done_set", LoadDone, 1);
    chk("cpuinit_pulse", CpuInit, 1);
    chk("ready_in_done", LoadReady, 0);
    chk("word_count", WordCount, exp_cnt);
    chk("load_error", LoadError, exp_err);
    tick();
    chk("cpuinit_release", CpuInit, 0);
    chk("done_sticky", LoadDone, 1);
  endtask

  task automatic check_mem();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        Program = b[0]; InstAddress = 16'(a);
        #1;
        if (mknown[b][a]) chk($sformatf("fetch_b%0d_a%0d", b, a), InstOut, mdl[b][a]);
      end
    end
    Program = $urandom_range(1);
    InstAddress = 16'(DEPTH);
    #1;
    chk("fetch_oor_depth", InstOut, 0);
    InstAddress = 16'($urandom_range(65535, DEPTH + 1));
    #1;
    chk("fetch_oor_rand", InstOut, 0);
    InstAddress = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] x;
    int         n;
    Init = 0; LoadStart = 0; LoadBank = 0; LoadValid = 0; LoadLast = 0;
    LoadData = 0; Program = 0; InstAddress = 0;
    for (int b = 0; b < 2; b++) for (int a = 0; a < DEPTH; a++) mknown[b][a] = 0;

    // Reset for two cycles
    tick();
    chk("rst_cpuinit", CpuInit, 1);
    chk("rst_ready", LoadReady, 0);
    tick();
    chk("rst_done", LoadDone, 0);
    chk("rst_error", LoadError, 0);
    chk("rst_count", WordCount, 0);
    Init = 1;
    tick();
    chk("idle_cpuinit", CpuInit, 0);
    chk("idle_ready", LoadReady, 0);

    // Basic load of bank0 with known halves
    words = {10'h245, 10'h3FF};
    do_load(0, 0, 0);
`ifndef LOADER_CHECKSUM_EN
    Program = 0; InstAddress = 0; #1;
    chk("basic_a0", InstOut, 10'h245);
    InstAddress = 1; #1;
    chk("basic_a1", InstOut, 10'h3FF);
`endif
    check_mem();

    // Bank1 with valid toggling every cycle and a stray LoadStart mid-load
    words = {};
    for (int i = 0; i < 3; i++) words.push_back(10'($urandom));
    do_load(1, 1, 1);
    check_mem();

    // Overflow: DEPTH+1 words into bank0
    words = {};
    for (int i = 0; i < DEPTH + 1; i++) words.push_back(10'($urandom));
    do_load(0, 0, 0);
    check_mem();

    // Reset while in RX_LO after one completed word
    x = 10'($urandom);
    LoadStart = 1; LoadBank = 1;
    tick();
    LoadStart = 0;
    send_half(x[9:5], 0, 0, 0, 1);
    send_half(x[4:0], 0, 0, 0, 1);
    mdl[1][0] = x; mknown[1][0] = 1;
    send_half(5'($urandom), 0, 0, 0, 1);
    Init = 0;
    #1;
    chk("midrst_cpuinit_comb", CpuInit, 1);
    tick();
    chk("midrst_ready", LoadReady, 0);
    chk("midrst_count", WordCount, 0);
    chk("midrst_done", LoadDone, 0);
    Init = 1;
    tick();
    chk("midrst_idle_cpuinit", CpuInit, 0);
    check_mem();

`ifdef LOADER_CHECKSUM_EN
    words = {10'h001, 10'h002, 10'h003};
    do_load(0, 0, 0);
    chk("csum_ok_err", LoadError, 0);
    chk("csum_ok_cnt", WordCount, 2);
    words = {10'h001, 10'h002, 10'h007};
    do_load(0, 0, 0);
    chk("csum_bad_err", LoadError, 1);
    check_mem();
`endif

    // Randomized loads against the model
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(6, 1);
      words = {};
      for (int i = 0; i < n; i++) words.push_back(10'($urandom));
`ifdef LOADER_CHECKSUM_EN
      if (k % 2 == 1) begin
        x = '0;
        for (int i = 0; i < n - 1 && i < DEPTH; i++) x ^= words[i];
        words[n-1] = x;
      end
`endif
      do_load($urandom_range(1), $urandom_range(1), $urandom_range(1));
      check_mem();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
